// File: rtl/uart_tx.sv
// UART transmitter: serialises one word per tx_start into start, data (LSB first),
// optional parity and stop bits on txd, with an internal baud-period counter.
module uart_tx #(
    parameter int unsigned CLK_FREQUENCE = 50_000_000,
    parameter int unsigned BPS           = 9600,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned PARITY        = 0,
    parameter int unsigned STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 txd
);

    localparam int unsigned BAUD_CNT = CLK_FREQUENCE / BPS;
    localparam int unsigned STOP_CNT = STOP_BITS * BAUD_CNT;
    localparam int unsigned CW       = $clog2(STOP_CNT + 1);
    localparam int unsigned IW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_CNT - 1);
    // The IDLE cycle carrying tx_done is the final clock of the last stop bit, so STOP
    // leaves one count early; a start accepted in that cycle then follows with no gap.
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CNT - 2);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            cnt     <= cnt + 1'b1;
            unique case (state)
                StIdle: begin
                    cnt <= '0;
                    txd <= 1'b1;
                    if (tx_start) begin
                        shift   <= tx_data;
                        par_bit <= (PARITY == 2) ? ~^tx_data : ^tx_data;
                        idx     <= '0;
                        txd     <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= StStart;
                    end
                end
                StStart: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        txd   <= shift[0];
                        shift <= shift >> 1;
                        state <= StData;
                    end
                end
                StData: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            if (PARITY != 0) begin
                                txd   <= par_bit;
                                state <= StParity;
                            end else begin
                                txd   <= 1'b1;
                                state <= StStop;
                            end
                        end else begin
                            idx   <= idx + 1'b1;
                            txd   <= shift[0];
                            shift <= shift >> 1;
                        end
                    end
                end
                StParity: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        txd   <= 1'b1;
                        state <= StStop;
                    end
                end
                StStop: begin
                    if (cnt == STOP_LAST) begin
                        cnt     <= '0;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                        state   <= StIdle;
                    end
                end
                default: begin
                    txd     <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2) share stimulus; per-instance
// monitors decode txd cycle by cycle against a scoreboard of expected frames.
module tb_uart_tx;

    localparam int unsigned NI = 4;
    localparam int unsigned BAUD = 10;
    localparam int unsigned PAR_CFG [NI] = '{0, 1, 2, 0};
    localparam int unsigned STP_CFG [NI] = '{1, 1, 1, 2};

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       po;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic [NI-1:0] txd_v;
    logic [NI-1:0] busy_v;
    logic [NI-1:0] done_v;

    int   checks   = 0;
    int   failures = 0;
    vec_t exp_q [NI][$];
    int   exp_done [NI] = '{default: 0};
    int   done_cnt [NI] = '{default: 0};
    vec_t vecs [8];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx #(
            .CLK_FREQUENCE(50_000_000),
            .BPS          (5_000_000),
            .DATA_BITS    (8),
            .PARITY       (PAR_CFG[g]),
            .STOP_BITS    (STP_CFG[g])
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .tx_start(tx_start),
            .tx_data (tx_data),
            .tx_busy (busy_v[g]),
            .tx_done (done_v[g]),
            .txd     (txd_v[g])
        );
    end

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (!rst && done_v[g]) done_cnt[g] <= done_cnt[g] + 1;
        end
    end

    // Frame monitors: one per instance, checking every clock of every bit.
    for (genvar g = 0; g < NI; g++) begin : g_mon
        initial begin
            logic        prev;
            logic [11:0] bits;
            vec_t        e;
            int          nbits;
            int          errs;
            logic        aborted;
            logic        tim_err;
            logic        last;
            prev = 1'b1;
            forever begin
                @(negedge clk);
                if (rst) begin
                    prev = 1'b1;
                    continue;
                end
                if (prev && !txd_v[g]) begin
                    if (exp_q[g].size() == 0) begin
                        check(1'b0, "unexpected_frame", g, -1);
                        e = '0;
                    end else begin
                        e = exp_q[g].pop_front();
                    end
                    bits = '0;
                    bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) bits[1+i] = e.data[i];
                    nbits = 9;
                    if (PAR_CFG[g] != 0) begin
                        bits[nbits] = (PAR_CFG[g] == 1) ? e.pe : e.po;
                        nbits++;
                    end
                    for (int s = 0; s < int'(STP_CFG[g]); s++) begin
                        bits[nbits] = 1'b1;
                        nbits++;
                    end
                    aborted = 1'b0;
                    tim_err = 1'b0;
                    for (int b = 0; b < nbits; b++) begin
                        errs = 0;
                        for (int c = 0; c < int'(BAUD); c++) begin
                            if (!(b == 0 && c == 0)) @(negedge clk);
                            if (rst) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (txd_v[g] !== bits[b]) errs++;
                            last = (b == nbits - 1) && (c == int'(BAUD) - 1);
                            if (done_v[g] !== last || busy_v[g] !== !last) tim_err = 1'b1;
                        end
                        if (aborted) break;
                        check(errs == 0, $sformatf("frame_bit inst=%0d data=%02h bit=%0d", g,
                              e.data, b), errs, 0);
                    end
                    if (!aborted) begin
                        check(tim_err == 1'b0, $sformatf("busy_done_timing inst=%0d", g),
                              int'(tim_err), 0);
                    end
                    prev = aborted ? 1'b1 : txd_v[g];
                end else begin
                    prev = txd_v[g];
                end
            end
        end
    end

    task automatic send(input vec_t v);
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = v.data;
        for (int g = 0; g < NI; g++) begin
            exp_q[g].push_back(v);
            exp_done[g]++;
        end
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        tx_data  = ~v.data;
        @(negedge clk);
        check(txd_v == '0, "start_latency_txd", int'(txd_v), 0);
        check(busy_v == '1, "start_busy", int'(busy_v), 15);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_v != '0 || done_v != '0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(n < 400, "idle_timeout", n, 400);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int hi_err;
        int n;
        vecs[0] = '{8'hA5, 1'b0, 1'b1};
        vecs[1] = '{8'h07, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1};
        vecs[4] = '{8'h01, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b0};
        vecs[6] = '{8'hC3, 1'b0, 1'b1};
        vecs[7] = '{8'h2A, 1'b1, 1'b0};

        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check(txd_v == '1, "reset_txd", int'(txd_v), 15);
        check(busy_v == '0, "reset_busy", int'(busy_v), 0);
        check(done_v == '0, "reset_done", int'(done_v), 0);
        hi_err = 0;
        repeat (20) begin
            @(negedge clk);
            if (txd_v != '1 || busy_v != '0) hi_err++;
        end
        check(hi_err == 0, "idle_line_high", hi_err, 0);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i]);
            wait_idle();
        end

        // tx_start while busy must be ignored
        send('{8'h3C, 1'b0, 1'b1});
        repeat (35) @(negedge clk);
        tx_start = 1'b1;
        tx_data  = 8'hFF;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        wait_idle();

        // Back-to-back: second start issued in the tx_done cycle of the 2-stop instance
        send('{8'h55, 1'b0, 1'b1});
        n = 0;
        while (!done_v[3] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(n < 300, "b2b_done_timeout", n, 300);
        tx_start = 1'b1;
        tx_data  = 8'hAA;
        for (int g = 0; g < NI; g++) begin
            exp_q[g].push_back('{8'hAA, 1'b0, 1'b1});
            exp_done[g]++;
        end
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        @(negedge clk);
        check(txd_v == '0, "b2b_zero_gap", int'(txd_v), 0);
        wait_idle();

        // Reset in the middle of the data bits
        send('{8'hA5, 1'b0, 1'b1});
        repeat (47) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check(txd_v == '1, "async_reset_txd", int'(txd_v), 15);
        check(busy_v == '0, "async_reset_busy", int'(busy_v), 0);
        for (int g = 0; g < NI; g++) exp_done[g]--;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send('{8'h81, 1'b0, 1'b1});
        wait_idle();

        repeat (5) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check(exp_q[g].size() == 0, $sformatf("queue_drained inst=%0d", g),
                  exp_q[g].size(), 0);
            check(done_cnt[g] == exp_done[g], $sformatf("done_count inst=%0d", g),
                  done_cnt[g], exp_done[g]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
